// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor. The add is cut into STAGES carry segments.
// A single global advance (en) either shifts every stage one place or holds the whole pipe.
module adder_pipe_nbit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    // Stage k adds bits [HI-1:LO]. It forwards the unprocessed upper operand bits
    // and the sum bits already computed. Data regs load only on valid, so idle
    // inputs never reach the outputs.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO = k * SEG;
        localparam int unsigned HI = LO + SEG;

        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic              c_in;
        logic              v_in;
        logic [SEG:0]      seg_res;
        logic [HI-1:0]     s_nxt;
        logic [HI-1:0]     s_q;
        logic              c_q;
        logic              v_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign s_nxt = seg_res[SEG-1:0];
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_fwd.a_q;
            assign b_in  = g_stg[k-1].g_fwd.b_q;
            assign c_in  = g_stg[k-1].c_q;
            assign v_in  = g_stg[k-1].v_q;
            assign s_nxt = {seg_res[SEG-1:0], g_stg[k-1].s_q};
        end

        assign seg_res = {1'b0, a_in[HI-1:LO]} + {1'b0, b_in[HI-1:LO]} + (SEG+1)'(c_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (en) begin
                v_q <= v_in;
                if (v_in) begin
                    s_q <= s_nxt;
                    c_q <= seg_res[SEG];
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_in) begin
                    a_q <= a_in[WIDTH-1:HI];
                    b_q <= b_in[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic ov_q;

            // Signed overflow: same-sign operands whose result has the other sign.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (en && v_in) begin
                    ov_q <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (seg_res[SEG-1] != a_in[WIDTH-1]);
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign overflow  = g_stg[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit (WIDTH=32, STAGES=4).
// It compares the DUT against a signed/unsigned arithmetic reference model.
module tb_adder_pipe_nbit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // {overflow, cout, sum}
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];

    // Directed vectors: a, b, cin, sub -> sum, cout, overflow
    logic [31:0] va [6] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h7FFFFFFF, 32'h00FFFFFF, 32'h0000000A};
    logic [31:0] vb [6] = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000003};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] vsum [6] = '{32'h00000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'h01000000, 32'h00000007};
    logic        vco [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    adder_pipe_nbit #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: true signed result decides overflow; unsigned range decides carry/borrow.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        longint          sx;
        longint          sy;
        longint          r;
        longint unsigned u;
        logic            c;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r = sx - sy;
            c = (x >= y);
        end else begin
            r = sx + sy + longint'({63'd0, ci});
            u = {32'd0, x} + {32'd0, y} + {63'd0, ci};
            c = u[32];
        end
        return {(r > 64'sd2147483647) || (r < -64'sd2147483648), c, r[31:0]};
    endfunction

    // Transfers are recorded mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) got_q.push_back({overflow, cout, sum});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            n = 0;
            do begin
                step();
                in_valid = 1'b0;
                n++;
            end while (!out_valid && n < 10);
            checks++; if (n !== 4) begin errors++; $display("FAIL latency[%0d]: got %0d cycles want 4", i, n); end
            checks++; if (sum !== vsum[i]) begin errors++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, vsum[i]); end
            checks++; if (cout !== vco[i]) begin errors++; $display("FAIL dir_cout[%0d]: got %b want %b", i, cout, vco[i]); end
            checks++; if (overflow !== vov[i]) begin errors++; $display("FAIL dir_overflow[%0d]: got %b want %b", i, overflow, vov[i]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic want_v;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (n < 16) begin rand_ops(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", n, in_ready); end
            step();
            want_v = (n + 1 >= 4) && (n + 1 <= 19);
            checks++; if (out_valid !== want_v) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b want %b", n + 1, out_valid, want_v); end
        end
        step();
        checks++; if (got_q.size() != 16 || exp_q.size() != 16) begin
            errors++; $display("FAIL b2b_count: got %0d results want 16 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int          idx;
        int          c;
        logic        acc;
        logic [33:0] held;
        exp_q.delete(); got_q.delete();
        idx = 0; c = 0; held = '0;
        rand_ops();
        while (got_q.size() < 8 && c < 60) begin
            in_valid  = (idx < 8);
            out_ready = !(c >= 6 && c <= 8);
            #1;
            if (c >= 6 && c <= 8) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b want 1", c, out_valid); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
            end
            if (c == 6) held = {overflow, cout, sum};
            if (c >= 7 && c <= 9) begin
                checks++; if ({overflow, cout, sum} !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", c, {overflow, cout, sum}, held); end
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin idx++; rand_ops(); end
            c++;
        end
        checks++; if (c >= 60) begin errors++; $display("FAIL stall_timeout: got %0d results want 8", got_q.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        checks++; if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL stall_count: got %0d results want 8 (accepted %0d)", got_q.size(), exp_q.size());
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got out_valid %b want 0", out_valid); end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n < 3) begin rand_ops(); in_valid = 1'b1; end
            else in_valid = 1'b0;
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL midrst_sum: got %h want 0", sum); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int n = 0; n < 10; n++) begin
            rand_ops();
            in_valid = 1'b0;
            step();
            checks++; if (out_valid !== 1'b0 || sum !== 32'h0) begin
                errors++; $display("FAIL midrst_idle[%0d]: got valid %b sum %h want 0/0", n, out_valid, sum);
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d results want 0", got_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
Parametrised pipelined adder/subtractor with a valid/ready handshake. The WIDTH-bit operation is split into STAGES equal segments. Each segment's carry is registered into the next stage, so long adds close timing at high clock rates. It provides carry-in, carry-out and signed overflow, and sits in datapaths that need full-width add/sub at one result per cycle with backpressure.

Parameters:
WIDTH, 32, operand/result width in bits
STAGES, 4, pipeline depth = number of carry segments; WIDTH % STAGES must be 0, STAGES >= 1; SEG = WIDTH/STAGES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = add, 1 = subtract (a - b)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync-to-clk deassert edge not required): all pipeline registers and valid bits cleared.
  - Outputs during and after reset: out_valid=0, sum=0, cout=0, overflow=0.
  - in_ready=1 after reset, since the pipe is empty.
- Arithmetic:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin; cin is ignored when sub=1.
  - Result = a + b_eff + c0, modulo 2^WIDTH.
  - cout = carry out of bit WIDTH-1.
  - overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Segmentation:
  - Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the registered carry of stage k-1; stage 0 uses c0.
  - Unprocessed upper operand bits and sub/MSB info are skew-delayed alongside.
  - Already-computed lower sum bits are forwarded.
  - Stage STAGES-1 registers final sum/cout/overflow.
- Pipeline control, single global advance:
  - en = !out_valid || out_ready; in_ready = en (combinational).
  - When en=1, every stage shifts one place; a stage's valid bit loads in_valid from upstream (stage 0) or from the previous stage's valid bit.
  - When en=0, all stages hold and no operands are accepted.
  - Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled. STAGES=1 gives a single registered adder with latency 1.
- Throughput: one operation per cycle when out_ready is held high.
- Bubbles: an empty stage carries valid=0. Bubbles are not compressed (global stall); this is acceptable by design.
- Ordering: results are emitted in acceptance order with no loss or duplication under any out_ready pattern.
- Output stability: sum/cout/overflow are held stable while out_valid && !out_ready.
- Simultaneous input accept and output drain in the same cycle is supported: the pipe shifts, and occupancy is unchanged.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (async). No stale result appears after rst_n rises.
- Values on a/b/cin/sub when in_valid=0 have no effect on outputs.

Test Plan:
WIDTH=32, STAGES=4 for all scenarios.
1. Add 0xFFFFFFFF + 0x00000001, cin=0 → 4 cycles later: sum=0x00000000, cout=1, overflow=0. This checks the carry ripple through all segments.
2. Sub 0x00000005 - 0x00000007 → sum=0xFFFFFFFE, cout=0, overflow=0. Sub 0x80000000 - 0x00000001 → sum=0x7FFFFFFF, cout=1, overflow=1.
3. Add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, overflow=1, cout=0. Add 0x00FFFFFF + 0x00000000 with cin=1 → sum=0x01000000.
4. Stream 16 random ops back-to-back with out_ready=1 → out_valid continuous from cycle 4; results in order match the reference model; in_ready constantly 1.
5. Stream 8 ops, drop out_ready for 3 cycles while out_valid=1 → in_ready=0 for those cycles; output held stable; all 8 results delivered once, in order.
6. Assert rst_n=0 with 3 ops in flight → out_valid=0 immediately. After release with no new input, out_valid stays 0 for 10 cycles.
